// File: rtl/bsg_two_fifo_arst_width_p64.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bsg_two_fifo_arst_width_p64: two-entry ready/valid FIFO, async reset |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module bsg_two_fifo_arst_width_p64 #(
  parameter int width_p = 64
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic [width_p-1:0] data_i,
  input  logic               valid_i,
  output logic               ready_o,
  output logic [width_p-1:0] data_o,
  output logic               valid_o,
  input  logic               yumi_i,
  output logic [1:0]         count_o,
  output logic               overflow_o,
  output logic               underflow_o
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [width_p-1:0] r_mem [2];
  logic               r_wptr;
  logic               r_rptr;
  logic               r_ready;
  logic               r_valid;
  logic               r_overflow;
  logic               r_underflow;
  logic               w_enq;
  logic               w_deq;

  assign w_enq = valid_i & r_ready;
  assign w_deq = yumi_i & r_valid;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_EMPTY: if (w_enq) w_state_next = S_ONE;
      S_ONE: begin
        if (w_enq && !w_deq)      w_state_next = S_FULL;
        else if (!w_enq && w_deq) w_state_next = S_EMPTY;
      end
      S_FULL:  if (w_deq) w_state_next = S_ONE;
      default: w_state_next = S_EMPTY;
    endcase
  end

  // ready/valid are registered copies of the next-state decode, so neither
  // output has a combinational path from valid_i or yumi_i.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state     <= S_EMPTY;
      r_mem[0]    <= '0;
      r_mem[1]    <= '0;
      r_wptr      <= 1'b0;
      r_rptr      <= 1'b0;
      r_ready     <= 1'b1;
      r_valid     <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_enq) begin
        r_mem[r_wptr] <= data_i;
        r_wptr        <= ~r_wptr;
      end
      if (w_deq) r_rptr <= ~r_rptr;
      r_state <= w_state_next;
      r_ready <= (w_state_next != S_FULL);
      r_valid <= (w_state_next != S_EMPTY);
      if (valid_i && !r_ready) r_overflow  <= 1'b1;
      if (yumi_i && !r_valid)  r_underflow <= 1'b1;
    end
  end

  assign data_o      = r_mem[r_rptr];
  assign ready_o     = r_ready;
  assign valid_o     = r_valid;
  assign count_o     = r_state;
  assign overflow_o  = r_overflow;
  assign underflow_o = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_bsg_two_fifo_arst_width_p64.sv
`default_nettype none
// Scoreboard bench for bsg_two_fifo_arst_width_p64.
module tb_bsg_two_fifo_arst_width_p64;

  logic        clk_i = 1'b0;
  logic        reset_n_i;
  logic [63:0] data_i;
  logic        valid_i;
  logic        ready_o;
  logic [63:0] data_o;
  logic        valid_o;
  logic        yumi_i;
  logic [1:0]  count_o;
  logic        overflow_o;
  logic        underflow_o;

  int checks = 0;
  int failures = 0;

  logic [63:0] m_q[$];
  logic        m_ovf = 1'b0;
  logic        m_unf = 1'b0;

  bsg_two_fifo_arst_width_p64 #(.width_p(64)) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .data_i(data_i), .valid_i(valid_i),
    .ready_o(ready_o), .data_o(data_o), .valid_o(valid_o), .yumi_i(yumi_i),
    .count_o(count_o), .overflow_o(overflow_o), .underflow_o(underflow_o)
  );

  always #5 clk_i = ~clk_i;

  // One clock of stimulus; model and scoreboard advance in lock step.
  task automatic drive_cycle(input logic v, input logic [63:0] d, input logic y);
    logic       enq, deq;
    logic [6:0] exp_st, got_st;
    @(negedge clk_i);
    valid_i = v; data_i = d; yumi_i = y;
    enq = v && (m_q.size() < 2);
    deq = y && (m_q.size() > 0);
    #1;
    checks++;
    if (valid_o !== (m_q.size() != 0) || ready_o !== (m_q.size() != 2)) begin
      failures++;
      $display("FAIL pre_edge_handshake: valid_o=%b ready_o=%b expected valid=%b ready=%b",
               valid_o, ready_o, m_q.size() != 0, m_q.size() != 2);
    end
    if (deq) begin
      checks++;
      if (data_o !== m_q[0]) begin
        failures++;
        $display("FAIL deq_data: got %h expected %h", data_o, m_q[0]);
      end
    end
    if (v && m_q.size() == 2) m_ovf = 1'b1;
    if (y && m_q.size() == 0) m_unf = 1'b1;
    @(posedge clk_i);
    if (deq) void'(m_q.pop_front());
    if (enq) m_q.push_back(d);
    #1;
    exp_st = {2'(m_q.size()), m_q.size() != 2, m_q.size() != 0, m_ovf, m_unf, 1'b0};
    got_st = {count_o, ready_o, valid_o, overflow_o, underflow_o, 1'b0};
    checks++;
    if (got_st !== exp_st) begin
      failures++;
      $display("FAIL post_edge_state {count,ready,valid,ovf,unf}: got %b expected %b",
               got_st[6:1], exp_st[6:1]);
    end
    if (m_q.size() != 0) begin
      checks++;
      if (data_o !== m_q[0]) begin
        failures++;
        $display("FAIL head_data: got %h expected %h", data_o, m_q[0]);
      end
    end
  endtask

  task automatic check_reset_state(input string tag);
    checks++;
    if (count_o !== 2'd0 || ready_o !== 1'b1 || valid_o !== 1'b0 ||
        data_o !== 64'd0 || overflow_o !== 1'b0 || underflow_o !== 1'b0) begin
      failures++;
      $display("FAIL %s: count=%0d ready=%b valid=%b data=%h ovf=%b unf=%b expected 0 1 0 0 0 0",
               tag, count_o, ready_o, valid_o, data_o, overflow_o, underflow_o);
    end
  endtask

  task automatic test_reset;
    reset_n_i = 1'b1; valid_i = 1'b0; yumi_i = 1'b0; data_i = '0;
    #3 reset_n_i = 1'b0;
    #1 check_reset_state("reset_async");
    repeat (2) @(posedge clk_i);
    @(negedge clk_i) reset_n_i = 1'b1;
    m_q.delete(); m_ovf = 1'b0; m_unf = 1'b0;
    repeat (3) drive_cycle(1'b0, 64'd0, 1'b0);
    #1 check_reset_state("idle_after_release");
  endtask

  task automatic test_single_word;
    drive_cycle(1'b1, 64'hDEAD_BEEF_0123_4567, 1'b0);
    checks++;
    if (data_o !== 64'hDEAD_BEEF_0123_4567 || count_o !== 2'd1) begin
      failures++;
      $display("FAIL single_word: data=%h count=%0d expected deadbeef01234567 1", data_o, count_o);
    end
    drive_cycle(1'b0, 64'd0, 1'b1);
  endtask

  task automatic test_fill_block;
    drive_cycle(1'b1, 64'h1, 1'b0);
    drive_cycle(1'b1, 64'h2, 1'b0);
    drive_cycle(1'b1, 64'h3, 1'b0);
    checks++;
    if (overflow_o !== 1'b1 || count_o !== 2'd2 || ready_o !== 1'b0) begin
      failures++;
      $display("FAIL overflow_block: ovf=%b count=%0d ready=%b expected 1 2 0",
               overflow_o, count_o, ready_o);
    end
    drive_cycle(1'b0, 64'd0, 1'b1);
    drive_cycle(1'b0, 64'd0, 1'b1);
    drive_cycle(1'b0, 64'd0, 1'b0);
  endtask

  task automatic test_streaming;
    for (int i = 0; i < 16; i++) drive_cycle(1'b1, 64'h10 + 64'(i), 1'b1);
    checks++;
    if (count_o !== 2'd1 || data_o !== 64'h1F) begin
      failures++;
      $display("FAIL stream_settle: count=%0d data=%h expected 1 1f", count_o, data_o);
    end
    drive_cycle(1'b0, 64'd0, 1'b1);
  endtask

  task automatic test_underflow;
    drive_cycle(1'b0, 64'd0, 1'b1);
    checks++;
    if (underflow_o !== 1'b1 || count_o !== 2'd0) begin
      failures++;
      $display("FAIL underflow_set: unf=%b count=%0d expected 1 0", underflow_o, count_o);
    end
    drive_cycle(1'b1, 64'h55, 1'b0);
    drive_cycle(1'b0, 64'd0, 1'b1);
    checks++;
    if (underflow_o !== 1'b1) begin
      failures++;
      $display("FAIL underflow_sticky: unf=%b expected 1", underflow_o);
    end
  endtask

  task automatic test_reset_with_data;
    drive_cycle(1'b1, 64'hA, 1'b0);
    drive_cycle(1'b1, 64'hB, 1'b0);
    @(negedge clk_i);
    valid_i = 1'b0; yumi_i = 1'b0;
    #2 reset_n_i = 1'b0;
    #1 check_reset_state("reset_mid_full");
    m_q.delete(); m_ovf = 1'b0; m_unf = 1'b0;
    @(negedge clk_i) reset_n_i = 1'b1;
    drive_cycle(1'b1, 64'hC, 1'b0);
    checks++;
    if (data_o !== 64'hC) begin
      failures++;
      $display("FAIL first_after_reset: got %h expected c", data_o);
    end
    drive_cycle(1'b0, 64'd0, 1'b1);
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_fill_block();
    test_streaming();
    test_underflow();
    test_reset_with_data();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
